// File: rtl/rom_mp.sv
// Multi-port boot-loaded word memory: burst load FSM, byte-masked run-time writes, N_RD registered read ports.
// Define ROM_MP_BYPASS_EN to forward same-cycle write data into reads of the same word.
module rom_mp #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4096,
  parameter  int N_RD   = 2,
  localparam int ADDR_W = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_start_i,
  input  logic [ADDR_W-1:0]        load_len_i,
  input  logic                     load_valid_i,
  input  logic [DATA_W-1:0]        load_data_i,
  output logic                     load_ready_o,
  output logic                     load_done_o,
  input  logic                     wen_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [BE_W-1:0]          wbe_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [N_RD-1:0]          rd_valid_i,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [N_RD-1:0]          rd_ready_o,
  output logic [N_RD-1:0]          rd_rvalid_o,
  output logic [N_RD*DATA_W-1:0]   rd_data_o,
  output logic [N_RD-1:0]          rd_err_o
);

  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   ptr;
  logic [CNT_W-1:0]   len;
  logic               load_ready;
  logic               load_done;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               loading;
  logic               load_wr;
  logic               wr_ok;
  logic [IDX_W-1:0]   wr_idx;
  logic [DATA_W-1:0]  rd_word [N_RD];
  logic [N_RD-1:0]    rd_in;

  logic [N_RD-1:0]        vld_p1;
  logic [N_RD*DATA_W-1:0] rd_data_p1;
  logic [N_RD-1:0]        rd_err_p1;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> (OFF_W + IDX_W)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_len(input logic [ADDR_W-1:0] l);
    return (l > ADDR_W'(DEPTH)) ? CNT_W'(DEPTH) : l[CNT_W-1:0];
  endfunction

  assign loading      = (state == LOAD);
  assign load_wr      = loading && load_valid_i && !rst_i;
  assign wr_ok        = wen_i && !loading && in_range(waddr_i);
  assign wr_idx       = word_idx(waddr_i);
  assign load_ready_o = load_ready;
  assign load_done_o  = load_done;
  assign rd_ready_o   = loading ? '0 : rd_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ptr        <= '0;
      len        <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_done <= 1'b0;
          if (load_start_i) begin
            if (load_len_i != '0) begin
              state      <= LOAD;
              ptr        <= '0;
              len        <= clamp_len(load_len_i);
              load_ready <= 1'b1;
            end else begin
              state     <= DONE;
              load_done <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (load_valid_i) begin
            ptr <= ptr + CNT_W'(1);
            if (ptr + CNT_W'(1) == len) begin
              state      <= DONE;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          load_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never reset so a reset mid-load keeps the words already written.
  always_ff @(posedge clk_i) begin
    if (load_wr)
      mem[ptr[IDX_W-1:0]] <= load_data_i;
    else if (wr_ok)
      mem[wr_idx] <= merge(mem[wr_idx], wdata_i, wbe_i);
  end

  // p0: address decode and word fetch
  always_comb begin
    for (int k = 0; k < N_RD; k++) begin
      rd_in[k]   = in_range(rd_addr_i[k*ADDR_W +: ADDR_W]);
      rd_word[k] = mem[word_idx(rd_addr_i[k*ADDR_W +: ADDR_W])];
`ifdef ROM_MP_BYPASS_EN
      if (wr_ok && (word_idx(rd_addr_i[k*ADDR_W +: ADDR_W]) == wr_idx))
        rd_word[k] = merge(rd_word[k], wdata_i, wbe_i);
`endif
    end
  end

  // p1: registered response, data held until the next accepted read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1     <= '0;
      rd_data_p1 <= '0;
      rd_err_p1  <= '0;
    end else begin
      vld_p1 <= rd_ready_o;
      for (int k = 0; k < N_RD; k++) begin
        if (rd_ready_o[k]) begin
          rd_data_p1[k*DATA_W +: DATA_W] <= rd_in[k] ? rd_word[k] : '0;
          rd_err_p1[k]                   <= !rd_in[k];
        end
      end
    end
  end

  assign rd_rvalid_o = vld_p1;
  assign rd_data_o   = rd_data_p1;
  assign rd_err_o    = rd_err_p1;

endmodule
